// File: rtl/decode_ctrl_pipe.sv
// ID/EXE control register: decodes opcode to exe/mem/wb/branch controls, 1-cycle latency.
// RAW scoreboard stalls the producer via in_ready=0; freeze holds everything, flush squashes.
module decode_ctrl_pipe #(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int EXE_CMD_W = 4,
  parameter int HAZ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_W-1:0]     src1,
  input  logic [REG_W-1:0]     src2,
  input  logic [REG_W-1:0]     dest,
  input  logic                 freeze,
  input  logic                 flush,
  output logic                 in_ready,
  output logic                 hazard,
  output logic                 out_valid,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 wb_en,
  output logic                 is_imm,
  output logic                 illegal,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic [1:0]           branch_type,
  output logic [REG_W-1:0]     dest_out
);

  logic [EXE_CMD_W-1:0] d_exe;
  logic [1:0]           d_branch;
  logic                 d_mem_read, d_mem_write, d_wb_en, d_is_imm, d_illegal;
  logic                 use_src1, use_src2;
  logic                 accept;

  logic [HAZ_DEPTH-1:0]            sb_v;
  logic [HAZ_DEPTH-1:0][REG_W-1:0] sb_reg;

  always_comb begin
    d_exe       = '0;
    d_branch    = 2'b00;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_wb_en     = 1'b0;
    d_is_imm    = 1'b0;
    d_illegal   = 1'b0;
    use_src1    = 1'b0;
    use_src2    = 1'b0;
    case (int'(opcode))
      1, 3, 5, 6, 7, 8, 9, 10, 11, 12: begin
        d_wb_en = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1;
      end
      32, 33: begin
        d_is_imm = 1'b1; d_wb_en = 1'b1; use_src1 = 1'b1;
      end
      36: begin
        d_is_imm = 1'b1; d_mem_read = 1'b1; d_wb_en = 1'b1; use_src1 = 1'b1;
      end
      37: begin
        d_is_imm = 1'b1; d_mem_write = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1;
      end
      40: begin
        d_branch = 2'b01; d_is_imm = 1'b1; use_src1 = 1'b1;
      end
      41: begin
        d_branch = 2'b10; d_is_imm = 1'b1; use_src1 = 1'b1; use_src2 = 1'b1;
      end
      42:      d_branch  = 2'b11;
      default: d_illegal = 1'b1;
    endcase
    case (int'(opcode))
      3, 33:   d_exe = EXE_CMD_W'(2);
      5:       d_exe = EXE_CMD_W'(4);
      6:       d_exe = EXE_CMD_W'(5);
      7:       d_exe = EXE_CMD_W'(6);
      8:       d_exe = EXE_CMD_W'(7);
      9, 10:   d_exe = EXE_CMD_W'(8);
      11:      d_exe = EXE_CMD_W'(9);
      12:      d_exe = EXE_CMD_W'(10);
      default: d_exe = '0;
    endcase
  end

  // Register 0 never enters the scoreboard, so a zero source can never match a valid entry.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v[i] && ((use_src1 && src1 == sb_reg[i]) || (use_src2 && src2 == sb_reg[i])))
        hazard = 1'b1;
    end
    hazard = hazard & in_valid;
  end

  assign in_ready = ~freeze & (flush | ~hazard);
  assign accept   = in_valid & ~flush & ~hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      wb_en       <= 1'b0;
      is_imm      <= 1'b0;
      illegal     <= 1'b0;
      exe_cmd     <= '0;
      branch_type <= 2'b00;
      dest_out    <= '0;
      sb_v        <= '0;
      sb_reg      <= '0;
    end else if (!freeze) begin
      out_valid   <= accept;
      mem_read    <= accept & d_mem_read;
      mem_write   <= accept & d_mem_write;
      wb_en       <= accept & d_wb_en;
      is_imm      <= accept & d_is_imm;
      illegal     <= accept & d_illegal;
      exe_cmd     <= accept ? d_exe : '0;
      branch_type <= accept ? d_branch : 2'b00;
      dest_out    <= accept ? dest : '0;
      sb_v[0]     <= accept & d_wb_en & (dest != '0);
      sb_reg[0]   <= dest;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_reg[i] <= sb_reg[i-1];
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: table-driven decode model plus a history of recent writers.
module tb_decode_ctrl_pipe;

  localparam int HD = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, freeze, flush;
  logic [5:0] opcode;
  logic [4:0] src1, src2, dest;
  logic       in_ready, hazard, out_valid, mem_read, mem_write, wb_en, is_imm, illegal;
  logic [3:0] exe_cmd;
  logic [1:0] branch_type;
  logic [4:0] dest_out;

  int errors = 0;
  int checks = 0;

  decode_ctrl_pipe #(.OPCODE_W(6), .REG_W(5), .EXE_CMD_W(4), .HAZ_DEPTH(HD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
    .src1(src1), .src2(src2), .dest(dest), .freeze(freeze), .flush(flush),
    .in_ready(in_ready), .hazard(hazard), .out_valid(out_valid),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .is_imm(is_imm),
    .illegal(illegal), .exe_cmd(exe_cmd), .branch_type(branch_type), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [3:0] exe;
    logic [1:0] br;
    logic       mr, mw, wb, imm, ill;
    logic [4:0] dst;
  } ctl_t;

  localparam int EXE_TAB [0:12] = '{0, 0, 0, 2, 0, 4, 5, 6, 7, 8, 8, 9, 10};

  function automatic ctl_t decode_m(input int op, input logic [4:0] d);
    ctl_t c;
    c = '0;
    c.vld = 1'b1;
    c.dst = d;
    if (op >= 1 && op <= 12 && op != 2 && op != 4) begin
      c.wb  = 1'b1;
      c.exe = 4'(EXE_TAB[op]);
    end else begin
      case (op)
        32: begin c.imm = 1; c.wb = 1; end
        33: begin c.exe = 4'd2; c.imm = 1; c.wb = 1; end
        36: begin c.imm = 1; c.mr = 1; c.wb = 1; end
        37: begin c.imm = 1; c.mw = 1; end
        40: begin c.br = 2'b01; c.imm = 1; end
        41: begin c.br = 2'b10; c.imm = 1; end
        42: c.br = 2'b11;
        default: c.ill = 1;
      endcase
    end
    return c;
  endfunction

  // {reads src1, reads src2}
  function automatic logic [1:0] uses_m(input int op);
    if ((op >= 1 && op <= 12 && op != 2 && op != 4) || op == 37 || op == 41) return 2'b11;
    if (op == 32 || op == 33 || op == 36 || op == 40) return 2'b10;
    return 2'b00;
  endfunction

  // Model: hist[k] is the register written by the instruction accepted k+1 advancing cycles ago.
  int   hist[$];
  ctl_t exp_c;
  bit   primed = 0;

  always @(negedge clk) begin
    ctl_t       act;
    logic [1:0] u;
    bit         h, r, acc;
    int         nd;
    act = {out_valid, exe_cmd, branch_type, mem_read, mem_write, wb_en, is_imm, illegal, dest_out};
    if (primed) begin
      checks++;
      if (act !== exp_c) begin
        errors++;
        $display("FAIL outputs @%0t: got %h want %h", $time, act, exp_c);
      end
    end
    u = uses_m(int'(opcode));
    h = 0;
    foreach (hist[k])
      if (hist[k] != 0 && ((u[1] && int'(src1) == hist[k]) || (u[0] && int'(src2) == hist[k]))) h = 1;
    h = h && in_valid;
    r = !freeze && (flush || !h);
    if (primed && !rst) begin
      checks += 2;
      if (hazard !== h) begin
        errors++;
        $display("FAIL hazard @%0t: got %b want %b", $time, hazard, h);
      end
      if (in_ready !== r) begin
        errors++;
        $display("FAIL in_ready @%0t: got %b want %b", $time, in_ready, r);
      end
    end
    if (rst) begin
      exp_c = '0;
      hist = {};
      for (int k = 0; k < HD; k++) hist.push_back(0);
      primed = 1;
    end else if (!freeze) begin
      acc   = in_valid && !flush && !h;
      exp_c = acc ? decode_m(int'(opcode), dest) : '0;
      nd    = (acc && exp_c.wb) ? int'(dest) : 0;
      hist.push_front(nd);
      void'(hist.pop_back());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic put(input bit v, input int op, input int s1, input int s2, input int d);
    in_valid = v;
    opcode   = 6'(op);
    src1     = 5'(s1);
    src2     = 5'(s2);
    dest     = 5'(d);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; freeze = 0; flush = 0;
    put(1, 1, 0, 0, 1);
    cyc(); chk("rst1_valid", out_valid, 0); chk("rst1_wb", wb_en, 0);
    cyc(); chk("rst2_valid", out_valid, 0); chk("rst2_dest", dest_out, 0);
    rst = 0;

    // ADD r1 then dependent ADD r2: two bubbles, ADD lands on the fourth edge
    put(1, 1, 0, 0, 1); #1 chk("add1_rdy", in_ready, 1);
    cyc(); chk("add1_valid", out_valid, 1); chk("add1_dest", dest_out, 1);
    put(1, 1, 1, 0, 2); #1 chk("dep_haz0", hazard, 1);
    cyc(); chk("dep_bub1", out_valid, 0); chk("dep_haz1", hazard, 1);
    cyc(); chk("dep_bub2", out_valid, 0); chk("dep_haz2", hazard, 0);
    cyc(); chk("dep_valid", out_valid, 1); chk("dep_exe", exe_cmd, 0);
    chk("dep_wb", wb_en, 1); chk("dep_dest", dest_out, 2);

    // ADDI to r0 then SUB reading r0: back-to-back
    put(1, 32, 0, 0, 0); #1 chk("addi_haz", hazard, 0);
    cyc(); chk("addi_imm", is_imm, 1);
    put(1, 3, 0, 0, 4); #1 chk("sub_haz", hazard, 0);
    cyc(); chk("sub_valid", out_valid, 1); chk("sub_exe", exe_cmd, 2);

    // LD r3 then ST reading r3 through src2
    put(1, 36, 0, 0, 3);
    cyc(); chk("ld_mr", mem_read, 1);
    put(1, 37, 0, 3, 0); #1 chk("st_haz0", hazard, 1);
    cyc(); chk("st_haz1", hazard, 1);
    cyc(); chk("st_haz2", hazard, 0);
    cyc(); chk("st_mw", mem_write, 1); chk("st_imm", is_imm, 1); chk("st_wb", wb_en, 0);

    // BNE in flight, flush squashes the following ADD r5
    put(1, 41, 0, 0, 0);
    cyc(); chk("bne_br", branch_type, 2);
    put(1, 1, 0, 0, 5); flush = 1; #1 chk("flush_rdy", in_ready, 1);
    cyc(); chk("flush_bub", out_valid, 0); chk("flush_br", branch_type, 0);
    flush = 0;
    put(1, 1, 5, 0, 6); #1 chk("flush_nohaz", hazard, 0);
    cyc(); chk("after_flush_dest", dest_out, 6);

    // stall on r6, frozen for 3 cycles in the middle
    put(1, 1, 6, 0, 7);
    cyc(); chk("frz_bub", out_valid, 0);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz_rdy", in_ready, 0);
      cyc(); chk("frz_hold", out_valid, 0);
    end
    freeze = 0; #1 chk("frz_haz_kept", hazard, 1);
    cyc(); chk("frz_bub2", out_valid, 0);
    cyc(); chk("frz_dest", dest_out, 7);

    // illegal opcode leaves no scoreboard entry
    put(1, 63, 0, 0, 8);
    cyc(); chk("ill_flag", illegal, 1); chk("ill_valid", out_valid, 1);
    chk("ill_wb", wb_en, 0); chk("ill_exe", exe_cmd, 0);
    put(1, 1, 8, 0, 9); #1 chk("ill_nohaz", hazard, 0);
    cyc(); chk("after_ill_dest", dest_out, 9);

    // flush wins over a hazard
    put(1, 1, 9, 0, 10); flush = 1; #1 chk("fh_haz", hazard, 1); chk("fh_rdy", in_ready, 1);
    cyc(); chk("fh_bub", out_valid, 0);
    flush = 0;
    put(1, 1, 10, 0, 11);
    cyc(); chk("fh_nohaz_dest", dest_out, 11);

    // sweep every opcode with zero sources, freezing on a few of them
    for (int op = 0; op < 64; op++) begin
      put(1, op, 0, 0, op % 32);
      freeze = (op % 9 == 4);
      cyc();
      if (freeze) begin
        freeze = 0;
        cyc();
      end
    end
    put(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("idle_valid", out_valid, 0);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Registered, parametrised successor to the combinational opcode controller. It sits at the ID/EXE boundary. It decodes each instruction into execute, memory, writeback and branch controls and registers them. A HAZ_DEPTH-entry scoreboard of in-flight destinations produces a RAW hazard stall for a pipeline without forwarding. Freeze, flush and illegal-opcode reporting are also provided.

## Interface
- OPCODE_W, 6, opcode width; the table below uses values < 64.
- REG_W, 5, register-index width; register 0 is hardwired zero.
- EXE_CMD_W, 4, exe_cmd width.
- HAZ_DEPTH, 2, number of downstream stages before writeback is visible (≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on inputs.
- opcode  in  OPCODE_W  instruction opcode.
- src1, src2, dest  in  REG_W each  register indices.
- freeze  in  1  downstream memory stall; hold all state.
- flush  in  1  taken branch; squash current input and output stage.
- in_ready  out  1  combinational; input consumed this cycle.
- hazard  out  1  combinational RAW stall indication.
- out_valid, mem_read, mem_write, wb_en, is_imm, illegal  out  1 each  registered controls.
- exe_cmd  out  EXE_CMD_W  registered ALU command.
- branch_type  out  2  registered; 00 none, 01 BEZ, 10 BNE, 11 JMP.
- dest_out  out  REG_W  registered destination.

## Operation
- Decode table (opcode: exe_cmd, flags):
  - 1 ADD: exe_cmd 0.
  - 3 SUB: 2.
  - 5 AND: 4.
  - 6 OR: 5.
  - 7 NOR: 6.
  - 8 XOR: 7.
  - 9 SLA: 8.
  - 10 SLL: 8.
  - 11 SRA: 9.
  - 12 SRL: 10.
  - All of 1–12 set wb_en.
  - 32 ADDI: exe_cmd 0, imm, wb_en.
  - 33 SUBI: exe_cmd 2, imm, wb_en.
  - 36 LD: exe_cmd 0, imm, mem_read, wb_en.
  - 37 ST: exe_cmd 0, imm, mem_write.
  - 40 BEZ: branch 01, imm.
  - 41 BNE: branch 10, imm.
  - 42 JMP: branch 11.
  - Any other opcode: all controls 0 and illegal=1.
  - Unlisted fields are 0.
- Source usage:
  - R-type (1–12), ST and BNE read src1 and src2.
  - ADDI, SUBI, LD and BEZ read src1 only.
  - JMP and illegal opcodes read nothing.
  - A source equal to 0 never matches.
- Scoreboard: HAZ_DEPTH entries {v, reg}.
  - hazard = in_valid & a used source equals reg of any entry with v=1.
- Priority per cycle: rst > freeze > flush > hazard > normal.
  - rst: all outputs and scoreboard entries cleared to 0.
  - freeze: outputs and scoreboard hold; in_ready=0; flush and hazard ignored.
  - flush: output regs load a bubble (out_valid=0, all controls 0); entry[0] v=0; the scoreboard shifts; in_ready=1 and the input is discarded.
  - hazard: output regs load a bubble; entry[0] v=0; the scoreboard shifts; in_ready=0.
  - normal, in_valid=1: output regs load the decode with out_valid=1 and dest_out=dest; the scoreboard shifts; in_ready=1.
    - entry[0] = {wb_en & dest≠0, dest}.
    - Illegal opcode: out_valid=1, illegal=1, and no scoreboard entry is made.
  - normal, in_valid=0: bubble; the scoreboard shifts; in_ready=1.
- Shift means entry[i] ← entry[i−1] for i≥1, and the oldest entry is dropped.

## Timing
- Reset values: every registered output is 0; all scoreboard v=0.
- Decode latency: 1 cycle from the in_ready=1 edge to outputs.
- in_ready and hazard are combinational from the inputs, freeze and scoreboard; there is no path from the registered outputs.
- The producer must hold in_valid and the instruction fields stable until the in_ready=1 edge.
- A dependent instruction issued immediately after its producer stalls exactly HAZ_DEPTH cycles.
  - A producer k cycles earlier (k ≤ HAZ_DEPTH) causes a stall of HAZ_DEPTH−k+1 cycles.
- A stall does not extend while frozen: freeze holds the stall count as well.
- flush asserted during a hazard: flush wins, and the stalled input is discarded.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 and opcode 1 → all outputs 0 after each edge; in_ready is don't-care during rst.
- ADD dest=1, then ADD src1=1 dest=2, HAZ_DEPTH=2 → hazard=1 for 2 cycles with out_valid=0 bubbles; second ADD appears on cycle 4 with exe_cmd=0, wb_en=1, dest_out=2.
- ADDI dest=0, then SUB src1=0 src2=0 → no hazard; back-to-back out_valid=1; SUB exe_cmd=2.
- ST src2=3 following LD dest=3 → hazard on src2; ST output has mem_write=1, is_imm=1, wb_en=0.
- BNE in flight, then flush on the next cycle with ADD on the inputs → outputs become a bubble, in_ready=1, ADD never appears, and its dest creates no hazard.
- freeze for 3 cycles mid-stall, then opcode 63 → outputs held during freeze; afterwards illegal=1, out_valid=1, all controls 0, and no later hazard on its dest.
